// File: rtl/seq_shift_add_mul.sv
// Multi-cycle shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock,
// signed or unsigned per operation, valid/ready on both sides, one multiply in flight.
module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               accept;
  logic               last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(1));

  // Signed operands are reduced to magnitudes; the most negative value maps to 2^(W-1), which fits.
  assign mag_a = (signed_mode && data_a[WIDTH-1]) ? (~data_a + ONE_W) : data_a;
  assign mag_b = (signed_mode && data_b[WIDTH-1]) ? (~data_b + ONE_W) : data_b;

  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
      neg    <= signed_mode && (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
    end else if (state == CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      // Two's-complement negation of zero is zero, so no negative-zero special case is needed.
      if (last_step) begin
        product <= neg ? (~acc_sum + ONE_2W) : acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed WIDTH=8 checks plus a randomized WIDTH=4 run, with a queue of expected products.
module tb_seq_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0;
  logic [7:0]  data_a = '0, data_b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, signed_mode4 = 1'b0;
  logic [3:0]  data_a4 = '0, data_b4 = '0;
  logic        in_ready4, out_valid4, busy4;
  logic [7:0]  product4;

  logic [15:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_shift_add_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .data_a(data_a4), .data_b(data_b4), .signed_mode(signed_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] obs);
    if (sb_q.size() == 0) begin
      check({tag, "_q"}, 16'd0, 16'd1);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  // One WIDTH=8 operation: accept, measure latency, optionally stall the consumer, then hand off.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input int hold, input string tag);
    int          guard, lat, low;
    logic [15:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    check({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
    data_a = a; data_b = b; signed_mode = s; in_valid = 1'b1; out_ready = 1'b0;
    sb_q.push_back(exp);
    step();
    in_valid = 1'b0;
    data_a = 8'($urandom); data_b = 8'($urandom); signed_mode = 1'($urandom);
    lat = 0; low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) low++;
      step();
      lat++;
    end
    if (!in_ready) low++;
    check({tag, "_lat"}, 16'(lat), 16'd8);
    held = product;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; data_a = 8'($urandom); data_b = 8'($urandom);
      step();
      check({tag, "_hv"}, {15'd0, out_valid}, 16'd1);
      check({tag, "_hp"}, product, held);
      check({tag, "_hr"}, {15'd0, in_ready}, 16'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    pop_check({tag, "_prod"}, product);
    check({tag, "_low"}, 16'(low), 16'd9);
    step();
    out_ready = 1'b0;
    check({tag, "_ovd"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_ir"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [3:0] sa4, sb4;
    logic signed [7:0] ps4;
    logic [7:0]        exp4;
    logic              done;
    int                guard;

    step();
    step();
    check("rst_ir", {15'd0, in_ready}, 16'd1);
    check("rst_ov", {15'd0, out_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_prod", product, 16'h0000);
    rst = 1'b0;
    step();

    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u_ff_ff");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s_80_80");
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, "s_fd_05");
    op8(8'hFD, 8'h05, 1'b0, 16'h04F1, 0, "u_fd_05");
    op8(8'h00, 8'h80, 1'b1, 16'h0000, 0, "s_00_80");
    op8(8'hFF, 8'h00, 1'b1, 16'h0000, 0, "s_ff_00");
    op8(8'h01, 8'hFF, 0, 16'h00FF, 0, "u_01_ff");
    op8(8'hF9, 8'h09, 1'b1, 16'hFFC1, 5, "bp_f9_09");

    // Reset in the middle of a calculation must discard it without any out_valid pulse.
    data_a = 8'h55; data_b = 8'h66; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("mid_ov", {15'd0, out_valid}, 16'd0);
    check("mid_ir", {15'd0, in_ready}, 16'd1);
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_prod", product, 16'h0000);
    step();
    rst = 1'b0;
    step();
    op8(8'h12, 8'h34, 1'b0, 16'h03A8, 0, "post_rst");

    for (int i = 0; i < 200; i++) begin
      data_a4 = 4'($urandom); data_b4 = 4'($urandom); signed_mode4 = 1'($urandom);
      sa4 = data_a4; sb4 = data_b4;
      ps4 = sa4 * sb4;
      exp4 = signed_mode4 ? ps4 : ({4'd0, data_a4} * {4'd0, data_b4});
      guard = 0;
      while (!in_ready4 && guard < 50) begin step(); guard++; end
      in_valid4 = 1'b1;
      sb_q.push_back({8'd0, exp4});
      step();
      in_valid4 = 1'b0;
      data_a4 = 4'($urandom); data_b4 = 4'($urandom);
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        out_ready4 = 1'($urandom_range(0, 1));
        if (out_valid4 && out_ready4) begin
          pop_check("w4_prod", {8'd0, product4});
          done = 1'b1;
        end
        step();
      end
      out_ready4 = 1'b0;
      check("w4_done", {15'd0, done}, 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
